mem_arb: RTL and testbench
==========================

# mem_arb

Two-requester memory arbiter that shares the processor's single unified main memory between the instruction-cache miss path and the data-cache miss/writeback path. It sits between both cache controllers and the memory. It serialises their transactions one at a time with round-robin fairness and returns read data and a completion pulse to the winning side. It also gates new grants on halt, and keeps grant counters for the simulation log.

## Interface
Parameters:
- AW, 16, address width in bits
- DW, 16, data width in bits
- CW, 16, grant-counter width in bits

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-side read request; held high until i_done
- i_addr  in  AW  I-side read address; stable while i_req high
- d_req  in  1  D-side request; held high until d_done
- d_wr  in  1  D-side 1 = write, 0 = read; stable while d_req high
- d_addr  in  AW  D-side address
- d_wdata  in  DW  D-side write data
- halt  in  1  processor halted; blocks new grants
- mem_done  in  1  memory completion pulse
- mem_rdata  in  DW  memory read data; valid with mem_done
- mem_rd  out  1  one-cycle memory read strobe
- mem_wr  out  1  one-cycle memory write strobe
- mem_addr  out  AW  latched address of the current transaction
- mem_wdata  out  DW  latched write data
- i_done  out  1  one-cycle completion pulse to the I-side
- i_rdata  out  DW  read data; valid while i_done is high
- d_done  out  1  one-cycle completion pulse to the D-side
- d_rdata  out  DW  read data for D-side reads; 0 for writes
- busy  out  1  state is not IDLE
- i_grants  out  CW  saturating count of I grants
- d_grants  out  CW  saturating count of D grants

## Operation
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If halt=0 and any request is pending, pick a winner and go to ISSUE.
  - Latch the address, wr flag and write data, and record the owner.
  - Increment the owner's grant counter; it saturates at all-ones.
- Pick rule:
  - One requester pending: that requester wins.
  - Both pending: the side not granted last wins.
  - last_grant resets to I, so D wins the first tie.
  - last_grant updates on every grant.
- ISSUE: assert mem_rd or mem_wr for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold mem_addr and mem_wdata.
  - On mem_done, capture mem_rdata (forced to 0 for writes) and go to RESP.
- RESP:
  - Pulse the owner's done output with the captured data, then go to IDLE.
  - i_req and d_req are ignored in RESP, so a requester still holding req in its done cycle does not re-issue.
- mem_done is ignored outside WAIT.
- halt is sampled only in IDLE; an in-flight transaction always completes.
- mem_addr and mem_wdata hold their last values in IDLE; they are meaningful only when a strobe is high.
- Reset values:
  - All outputs are 0.
  - State = IDLE, last_grant = I, counters = 0.
  - Latched address, data and captured data are 0.
- Reset mid-transaction abandons the transaction; no done pulse is produced. Memory shares rst.

## Timing
- Request sampled at the edge ending cycle T → strobe in T+1 (ISSUE).
- Earliest mem_done is T+2; done pulse at T+3 (one cycle after mem_done).
- Total latency is memory latency + 2 cycles; the minimum is 3.
- Back-to-back service: next grant is decided in T+4 (IDLE), with its strobe in T+5.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the owner enum (OWN_I, OWN_D);
  - default widths.
- One sub-module, `rr_pick2`:
  - combinational 2-way round-robin picker;
  - inputs: req_i, req_d, last;
  - outputs: grant_valid, grant_owner.
- Everything else is a single FSM plus datapath registers.

## Test plan
- I read alone:
  - Stimulus: i_req=1, i_addr=0x0040; memory returns 0xBEEF two cycles after mem_rd.
  - Required: mem_rd pulse with mem_addr=0x0040; i_done pulse with i_rdata=0xBEEF; i_grants=1.
- D write alone:
  - Stimulus: d_wr=1, d_addr=0x1234, d_wdata=0x5A5A.
  - Required: mem_wr pulse with mem_addr=0x1234 and mem_wdata=0x5A5A; d_done pulse with d_rdata=0x0000.
- Tie after reset:
  - Stimulus: i_req and d_req raised in the same cycle.
  - Required: D served first, then I; with both held continuously, grants alternate D, I, D, I; final counters d_grants=2, i_grants=2.
- Halt:
  - Stimulus: halt=1 while IDLE with i_req high.
  - Required: no strobe for 10 cycles.
  - Stimulus: halt=1 raised during WAIT.
  - Required: the transaction still completes with a done pulse.
- Reset in WAIT:
  - Stimulus: rst=1 while in WAIT.
  - Required: next cycle busy=0, no done pulse, counters 0; a later D request is granted normally.
- Stray and held signals:
  - Stimulus: mem_done asserted in IDLE; requester holds req through its done cycle.
  - Required: no response to the stray mem_done; no duplicate transaction.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
package mem_arb_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie, the side not granted last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last,
    output logic grant_valid,
    output logic grant_owner
);
    always_comb begin
        grant_valid = req_i | req_d;
        if (req_i && req_d)
            grant_owner = (last == OWN_I) ? OWN_D : OWN_I;
        else
            grant_owner = req_d ? OWN_D : OWN_I;
    end
endmodule

// File: rtl/mem_arb.sv
// Serialises I-side reads and D-side reads/writes onto one memory port,
// round-robin on ties, with halt gating and saturating grant counters.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          halt,
    input  logic          mem_done,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          busy,
    output logic [CW-1:0] i_grants,
    output logic [CW-1:0] d_grants
);
    state_t        state, state_nxt;
    logic          pick_valid, pick_owner, grant;
    logic          last_q, owner_q, wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, rdata_q;

    rr_pick2 u_pick (
        .req_i       (i_req),
        .req_d       (d_req),
        .last        (last_q),
        .grant_valid (pick_valid),
        .grant_owner (pick_owner)
    );

    // Requests only count in IDLE, so a requester still holding req in RESP cannot re-issue.
    assign grant = (state == IDLE) && !halt && pick_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mem_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= OWN_I;
            owner_q  <= OWN_I;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            i_grants <= '0;
            d_grants <= '0;
        end else begin
            if (grant) begin
                owner_q <= pick_owner;
                last_q  <= pick_owner;
                if (pick_owner == OWN_D) begin
                    addr_q  <= d_addr;
                    wr_q    <= d_wr;
                    wdata_q <= d_wdata;
                    if (d_grants != '1) d_grants <= d_grants + 1'b1;
                end else begin
                    addr_q <= i_addr;
                    wr_q   <= 1'b0;
                    if (i_grants != '1) i_grants <= i_grants + 1'b1;
                end
            end
            if (state == WAIT && mem_done)
                rdata_q <= wr_q ? '0 : mem_rdata;
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        i_done = 1'b0;
        d_done = 1'b0;
        case (state)
            ISSUE: begin
                mem_rd = !wr_q;
                mem_wr = wr_q;
            end
            RESP: begin
                i_done = (owner_q == OWN_I);
                d_done = (owner_q == OWN_D);
            end
            default: ;
        endcase
    end

    assign busy      = (state != IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = rdata_q;
    assign d_rdata   = rdata_q;
endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: directed requesters, a latency-programmable memory, and a decoupled monitor.
module tb_mem_arb;
    localparam int AW = 16, DW = 16, CW = 16;

    logic          clk = 1'b0, rst = 1'b1;
    logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0, halt = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          mem_done = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rd, mem_wr, i_done, d_done, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, i_rdata, d_rdata;
    logic [CW-1:0] i_grants, d_grants;

    mem_arb #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .halt(halt), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .i_done(i_done), .i_rdata(i_rdata), .d_done(d_done), .d_rdata(d_rdata),
        .busy(busy), .i_grants(i_grants), .d_grants(d_grants)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          own;   // 1 = D side
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t str_q[$];
    exp_t done_q[$];
    int   checks = 0, failures = 0;
    int   lat = 1;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic own, input logic [DW-1:0] rd, input bit with_done);
        exp_t e;
        e.wr = wr; e.addr = a; e.wdata = wd; e.own = own; e.rdata = rd;
        str_q.push_back(e);
        if (with_done) done_q.push_back(e);
    endtask

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return (a == 16'h0040) ? 16'hBEEF : ~a;
    endfunction

    // Memory: mem_done arrives lat cycles after the strobe cycle; write responses carry junk data.
    initial begin
        logic          w;
        logic [AW-1:0] a;
        forever begin
            @(negedge clk);
            if (!rst && (mem_rd || mem_wr)) begin
                w = mem_wr; a = mem_addr;
                repeat (lat) @(posedge clk);
                #1 mem_done = 1'b1;
                mem_rdata = w ? 16'hDEAD : mem_val(a);
                @(posedge clk);
                #1 mem_done = 1'b0;
                mem_rdata = 16'h1111;
            end
        end
    end

    // Monitor: every strobe and every done pulse must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_rd && mem_wr) chk("strobe_excl", 1, 0);
                if (mem_rd || mem_wr) begin
                    if (str_q.size() == 0) chk("unexpected_strobe", {mem_wr, mem_addr}, 0);
                    else begin
                        e = str_q.pop_front();
                        chk("strobe_kind", mem_wr, e.wr);
                        chk("mem_addr", mem_addr, e.addr);
                        if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
                    end
                end
                if (i_done && d_done) chk("done_excl", 1, 0);
                if (i_done || d_done) begin
                    if (done_q.size() == 0) chk("unexpected_done", {d_done, i_done}, 0);
                    else begin
                        e = done_q.pop_front();
                        chk("done_owner", d_done, e.own);
                        if (d_done) chk("d_rdata", d_rdata, e.rdata);
                        else        chk("i_rdata", i_rdata, e.rdata);
                    end
                end
            end
        end
    end

    // Requesters hold req through their done cycle and drop it on the following edge.
    task automatic do_i(input int n, input logic [AW-1:0] base, output int dcyc);
        dcyc = 0;
        i_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            bit got = 0;
            i_addr = base + AW'(2 * k);
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (i_done) begin got = 1; break; end
            end
            if (!got) chk("i_timeout", 0, 1);
            dcyc = cyc;
            @(posedge clk); #1;
        end
        i_req = 1'b0;
    endtask

    task automatic do_d(input int n, input logic wr, input logic [AW-1:0] base,
                        input logic [DW-1:0] wbase, output int dcyc);
        dcyc = 0;
        d_req = 1'b1;
        d_wr  = wr;
        for (int k = 0; k < n; k++) begin
            bit got = 0;
            d_addr  = base + AW'(2 * k);
            d_wdata = wbase + DW'(k);
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (d_done) begin got = 1; break; end
            end
            if (!got) chk("d_timeout", 0, 1);
            dcyc = cyc;
            @(posedge clk); #1;
        end
        d_req = 1'b0;
        d_wr  = 1'b0;
    endtask

    initial begin
        int c0, ic, dc, s;
        bit seen;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_strobes", {mem_rd, mem_wr}, 0);
        chk("rst_done", {i_done, d_done}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grants", {i_grants, d_grants}, 0);
        chk("rst_addr_data", {mem_addr, mem_wdata}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        rst = 1'b0;

        // I read alone, memory answers two cycles after the strobe
        lat = 2;
        expect_txn(1'b0, 16'h0040, '0, 1'b0, 16'hBEEF, 1);
        c0 = cyc;
        do_i(1, 16'h0040, ic);
        chk("i_latency", ic - c0, 4);
        chk("i_grants_1", i_grants, 1);

        // D write alone, read data forced to zero
        lat = 1;
        expect_txn(1'b1, 16'h1234, 16'h5A5A, 1'b1, 16'h0000, 1);
        do_d(1, 1'b1, 16'h1234, 16'h5A5A, dc);
        chk("d_grants_1", d_grants, 1);

        // Tie right after reset: D first, then alternate D I D I
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst2_grants", {i_grants, d_grants}, 0);
        expect_txn(1'b0, 16'h2000, '0, 1'b1, 16'hDFFF, 1);
        expect_txn(1'b0, 16'h3000, '0, 1'b0, 16'hCFFF, 1);
        expect_txn(1'b0, 16'h2002, '0, 1'b1, 16'hDFFD, 1);
        expect_txn(1'b0, 16'h3002, '0, 1'b0, 16'hCFFD, 1);
        fork
            do_d(2, 1'b0, 16'h2000, '0, dc);
            do_i(2, 16'h3000, ic);
        join
        @(negedge clk);
        chk("tie_d_grants", d_grants, 2);
        chk("tie_i_grants", i_grants, 2);

        // Halt in IDLE blocks the grant for 10 cycles
        expect_txn(1'b0, 16'h0050, '0, 1'b0, 16'hFFAF, 1);
        halt = 1'b1;
        fork
            do_i(1, 16'h0050, ic);
            begin
                s = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (mem_rd || mem_wr || busy) s++;
                end
                chk("halt_no_strobe", s, 0);
                halt = 1'b0;
            end
        join
        chk("halt_i_grants", i_grants, 3);

        // Halt raised during WAIT does not stop the in-flight transaction
        lat = 4;
        expect_txn(1'b0, 16'h0100, '0, 1'b1, 16'hFEFF, 1);
        fork
            do_d(1, 1'b0, 16'h0100, '0, dc);
            begin
                seen = 0;
                for (int t = 0; t < 20; t++) begin
                    @(negedge clk);
                    if (mem_rd) begin seen = 1; break; end
                end
                @(negedge clk);
                chk("halt_wait_busy", {seen, busy}, 2'b11);
                halt = 1'b1;
            end
        join
        halt = 1'b0;
        chk("halt_d_grants", d_grants, 3);

        // Reset while in WAIT abandons the transaction
        lat = 6;
        expect_txn(1'b0, 16'h0200, '0, 1'b1, '0, 0);
        @(negedge clk);
        d_addr = 16'h0200; d_wr = 1'b0; d_req = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk("rstwait_busy", busy, 0);
        chk("rstwait_done", {i_done, d_done}, 0);
        chk("rstwait_grants", {i_grants, d_grants}, 0);
        rst = 1'b0;
        // The memory's late mem_done lands in IDLE and must be ignored
        repeat (12) @(negedge clk);
        chk("rstwait_idle", busy, 0);
        lat = 1;
        expect_txn(1'b1, 16'h0300, 16'h1357, 1'b1, 16'h0000, 1);
        do_d(1, 1'b1, 16'h0300, 16'h1357, dc);
        chk("post_rst_grants", {i_grants, d_grants}, {16'd0, 16'd1});

        // Stray mem_done in IDLE
        @(negedge clk);
        mem_done = 1'b1; mem_rdata = 16'h7777;
        @(negedge clk);
        mem_done = 1'b0;
        chk("stray_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("stray_idle", {busy, i_grants, d_grants}, {1'b0, 16'd0, 16'd1});

        chk("str_q_empty", str_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
